eig_sequencer: RTL

Central controller for the watchdog datapath: param_loader → eig_core → output_loader. It accepts a "parameters loaded" pulse and issues the eig_core start pulse. It then waits for the core result, issues the output_loader start pulse, and waits for serialization to finish. Every wait is bounded by a watchdog timeout, and the block reports status, errors and a run counter.

---
 rtl/eig_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/eig_sequencer.sv
// rtl/eig_sequencer.sv - watchdog-bounded start/wait sequencer for param_loader, eig_core and output_loader
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   ena               low freezes all state; start pulses are forced low
//   param_valid       pulse from param_loader: new coefficients latched
//   abort             level; drops any running sequence into ERROR
//   core_done         pulse from eig_core: result valid
//   ol_busy           output_loader is serializing
//   core_start        1-cycle start pulse to eig_core
//   ol_start          1-cycle start pulse to output_loader
//   loader_hold       param_loader must not update a0/a1
//   seq_busy          sequence in progress (not IDLE, not ERROR)
//   err, err_code     sticky error flag and cause (01 core, 10 output, 11 abort)
//   overrun           sticky; a param_valid pulse was dropped
//   run_count         completed sequences, wraps 255 -> 0
//   state_o           current state encoding
module eig_sequencer #(
   parameter int CNT_W        = 8,
   parameter int CORE_TIMEOUT = 200,
   parameter int OL_TIMEOUT   = 63
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic       param_valid,
   input  logic       abort,
   input  logic       core_done,
   input  logic       ol_busy,
   output logic       core_start,
   output logic       ol_start,
   output logic       loader_hold,
   output logic       seq_busy,
   output logic       err,
   output logic [1:0] err_code,
   output logic       overrun,
   output logic [7:0] run_count,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_CORE_START = 3'd1,
      ST_CORE_WAIT  = 3'd2,
      ST_OL_START   = 3'd3,
      ST_OL_WAIT    = 3'd4,
      ST_DONE       = 3'd5,
      ST_ERROR      = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] CORE_TO   = CNT_W'(CORE_TIMEOUT);
   localparam logic [CNT_W-1:0] OL_TO     = CNT_W'(OL_TIMEOUT);
   localparam logic [CNT_W-1:0] TIMER_ONE = CNT_W'(1);

   state_t           state_q;
   logic [CNT_W-1:0] timer_q;
   logic             pending_q;
   logic             seen_q;
   logic             err_q;
   logic [1:0]       err_code_q;
   logic             overrun_q;
   logic [7:0]       run_count_q;
   logic             busy;

   assign busy = (state_q != ST_IDLE) && (state_q != ST_ERROR);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         pending_q   <= 1'b0;
         seen_q      <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= 2'b00;
         overrun_q   <= 1'b0;
         run_count_q <= 8'd0;
      end else if (ena) begin
         // One request may queue behind a running sequence; a second is dropped.
         if (param_valid && busy) begin
            if (pending_q) begin
               overrun_q <= 1'b1;
            end else begin
               pending_q <= 1'b1;
            end
         end

         if (abort && busy) begin
            state_q    <= ST_ERROR;
            err_q      <= 1'b1;
            err_code_q <= 2'b11;
            pending_q  <= 1'b0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (param_valid || pending_q) begin
                     state_q   <= ST_CORE_START;
                     pending_q <= 1'b0;
                  end
               end
               ST_CORE_START: begin
                  timer_q <= '0;
                  state_q <= ST_CORE_WAIT;
               end
               ST_CORE_WAIT: begin
                  // core_done is checked first so it still wins on the last allowed cycle.
                  if (core_done) begin
                     timer_q <= '0;
                     state_q <= ST_OL_START;
                  end else if (timer_q == CORE_TO) begin
                     state_q    <= ST_ERROR;
                     err_q      <= 1'b1;
                     err_code_q <= 2'b01;
                     pending_q  <= 1'b0;
                  end else begin
                     timer_q <= timer_q + TIMER_ONE;
                  end
               end
               ST_OL_START: begin
                  if (!ol_busy) begin
                     // Timer spans OL_START and OL_WAIT together; saturate so the
                     // OL_WAIT equality check can never be skipped over.
                     state_q <= ST_OL_WAIT;
                     seen_q  <= 1'b0;
                     if (timer_q != OL_TO) begin
                        timer_q <= timer_q + TIMER_ONE;
                     end
                  end else if (timer_q == OL_TO) begin
                     state_q    <= ST_ERROR;
                     err_q      <= 1'b1;
                     err_code_q <= 2'b10;
                     pending_q  <= 1'b0;
                  end else begin
                     timer_q <= timer_q + TIMER_ONE;
                  end
               end
               ST_OL_WAIT: begin
                  if (ol_busy) begin
                     seen_q <= 1'b1;
                  end
                  // Finished only once busy has been observed high and then dropped.
                  if (seen_q && !ol_busy) begin
                     state_q <= ST_DONE;
                  end else if (timer_q == OL_TO) begin
                     state_q    <= ST_ERROR;
                     err_q      <= 1'b1;
                     err_code_q <= 2'b10;
                     pending_q  <= 1'b0;
                  end else begin
                     timer_q <= timer_q + TIMER_ONE;
                  end
               end
               ST_DONE: begin
                  run_count_q <= run_count_q + 8'd1;
                  state_q     <= ST_IDLE;
               end
               ST_ERROR: begin
                  if (param_valid) begin
                     err_q      <= 1'b0;
                     err_code_q <= 2'b00;
                     state_q    <= ST_CORE_START;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Start pulses are decoded from state so that ena and abort can suppress
   // them in the very cycle they apply.
   assign core_start  = ena && !abort && (state_q == ST_CORE_START);
   assign ol_start    = ena && !abort && (state_q == ST_OL_START) && !ol_busy;
   assign seq_busy    = busy;
   assign loader_hold = busy;
   assign err         = err_q;
   assign err_code    = err_code_q;
   assign overrun     = overrun_q;
   assign run_count   = run_count_q;
   assign state_o     = state_q;

endmodule
